fibonacci_wb_regs: RTL and testbench

//  Wishbone classic slave register front end plus iterative Fibonacci engine; instantiated inside

---
 rtl/fibonacci_pkg.sv | 24 ++
 rtl/fibonacci_engine.sv | 77 +++++++
 rtl/fibonacci_wb_regs.sv | 107 ++++++++++
 tb/tb_fibonacci_wb_regs.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fibonacci_pkg.sv
// Shared register offsets, bit positions and FSM state type for the Fibonacci
// Wishbone peripheral.
package fibonacci_pkg;

  // Word offsets, i.e. adr[7:2]
  localparam logic [5:0] OFF_CTRL   = 6'h00;
  localparam logic [5:0] OFF_COUNT  = 6'h01;
  localparam logic [5:0] OFF_STAT   = 6'h02;
  localparam logic [5:0] OFF_RESULT = 6'h03;
  localparam logic [5:0] OFF_INDEX  = 6'h04;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_OVF_BIT  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fib_state_t;

endpackage

// File: rtl/fibonacci_engine.sv
// Iterative Fibonacci engine: one term per cycle, N+1 busy cycles per run.
// START is ignored while running; there is no downstream backpressure.
module fibonacci_engine
  import fibonacci_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IDX_W-1:0] n,
  output logic             busy,
  output logic             done_pulse,
  output logic             ovf_set,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] value,
  output logic [IDX_W-1:0] idx
);

  fib_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH:0]   b_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] n_q;
  logic [WIDTH-1:0] result_q;
  logic             last;

  assign last = (idx_q == n_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy       = (state_q == ST_RUN);
  assign done_pulse = busy && last;
  // Only a carry that actually moves into a counts as overflow
  assign ovf_set    = busy && !last && b_q[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      n_q      <= '0;
      result_q <= '0;
    end else if (state_q == ST_IDLE) begin
      if (start) begin
        a_q   <= '0;
        b_q   <= {{WIDTH{1'b0}}, 1'b1};
        idx_q <= '0;
        n_q   <= n;
      end
    end else if (last) begin
      result_q <= a_q;
    end else begin
      a_q   <= b_q[WIDTH-1:0];
      b_q   <= {1'b0, a_q} + {1'b0, b_q[WIDTH-1:0]};
      idx_q <= idx_q + 1'b1;
    end
  end

  assign result = result_q;
  assign value  = a_q;
  assign idx    = idx_q;

endmodule

// File: rtl/fibonacci_wb_regs.sv
// Wishbone classic slave registers around the Fibonacci engine; ack one cycle after
// request, one ack per two cycles on a held strobe, misses never acked.
module fibonacci_wb_regs
  import fibonacci_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          WIDTH     = 32,
  parameter int          IDX_W     = 6
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic [WIDTH-1:0] fib_value_o,
  output logic             busy_o,
  output logic             irq_o
);

  logic             hit, req, wr, ack_q;
  logic [5:0]       off;
  logic             start, start_acc, stat_wr;
  logic             irq_en_q, done_q, ovf_q;
  logic [IDX_W-1:0] count_q;
  logic             busy, done_pulse, ovf_set;
  logic [WIDTH-1:0] result;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_dat;
  logic             unused_ok;

  assign hit = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign req = wbs_stb_i && wbs_cyc_i && hit;
  assign off = wbs_adr_i[7:2];
  // Writes land on the edge that closes the ack cycle
  assign wr  = ack_q && req && wbs_we_i;

  assign start     = wr && (off == OFF_CTRL) && wbs_sel_i[0] && wbs_dat_i[CTRL_START_BIT];
  assign start_acc = start && !busy;
  assign stat_wr   = wr && (off == OFF_STAT) && wbs_sel_i[0];

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q    <= 1'b0;
      irq_en_q <= 1'b0;
      count_q  <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      ack_q <= req && !ack_q;
      if (wr && (off == OFF_CTRL) && wbs_sel_i[0])
        irq_en_q <= wbs_dat_i[CTRL_IRQ_EN_BIT];
      for (int i = 0; i < IDX_W; i++)
        if (wr && (off == OFF_COUNT) && wbs_sel_i[i/8])
          count_q[i] <= wbs_dat_i[i];
      // A completing run beats a same-cycle W1C
      done_q <= done_pulse ||
                (done_q && !(start_acc || (stat_wr && wbs_dat_i[STAT_DONE_BIT])));
      ovf_q  <= ovf_set ||
                (ovf_q && !(start_acc || (stat_wr && wbs_dat_i[STAT_OVF_BIT])));
    end
  end

  fibonacci_engine #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_engine (
    .clk        (wb_clk_i),
    .rst_n      (wb_rst_n_i),
    .start      (start),
    .n          (count_q),
    .busy       (busy),
    .done_pulse (done_pulse),
    .ovf_set    (ovf_set),
    .result     (result),
    .value      (fib_value_o),
    .idx        (idx)
  );

  always_comb begin
    rd_dat = '0;
    case (off)
      OFF_CTRL:   rd_dat[CTRL_IRQ_EN_BIT] = irq_en_q;
      OFF_COUNT:  rd_dat[IDX_W-1:0] = count_q;
      OFF_STAT: begin
        rd_dat[STAT_BUSY_BIT] = busy;
        rd_dat[STAT_DONE_BIT] = done_q;
        rd_dat[STAT_OVF_BIT]  = ovf_q;
      end
      OFF_RESULT: rd_dat[WIDTH-1:0] = result;
      OFF_INDEX:  rd_dat[IDX_W-1:0] = idx;
      default:    rd_dat = '0;
    endcase
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = ack_q ? rd_dat : 32'h0;
  assign busy_o    = busy;
  assign irq_o     = done_q && irq_en_q;

  assign unused_ok = ^{wbs_adr_i[1:0], wbs_sel_i, wbs_dat_i};

endmodule

// File: tb/tb_fibonacci_wb_regs.sv
// Directed bench for fibonacci_wb_regs: vector table of runs plus bus and reset corner sequences.
module tb_fibonacci_wb_regs;

  localparam logic [31:0] A_CTRL   = 32'h3000_0000;
  localparam logic [31:0] A_COUNT  = 32'h3000_0004;
  localparam logic [31:0] A_STAT   = 32'h3000_0008;
  localparam logic [31:0] A_RESULT = 32'h3000_000C;
  localparam logic [31:0] A_INDEX  = 32'h3000_0010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i, dat_o;
  logic        ack;
  logic [31:0] fib_value;
  logic        busy, irq;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  fibonacci_wb_regs dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .wbs_stb_i   (stb),
    .wbs_cyc_i   (cyc),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (dat_i),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (dat_o),
    .fib_value_o (fib_value),
    .busy_o      (busy),
    .irq_o       (irq)
  );

  typedef struct {
    logic [5:0]  n;
    logic        irq_en;
    logic [31:0] res;
    logic [2:0]  stat;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wb_cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rdat);
    logic ok;
    ok = 1'b0;
    rdat = '0;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) begin
        ok = 1'b1;
        rdat = dat_o;
        break;
      end
    end
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
    if (!ok) begin
      vecs++;
      errs++;
      $display("FAIL ack_timeout: adr 0x%08h got no ack, expected one within 8 cycles", a);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_cycle(1'b1, a, d, 4'hF, dummy);
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    wb_cycle(1'b0, a, 32'h0, 4'hF, r);
    check(name, r, exp);
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    if (busy) begin
      vecs++;
      errs++;
      $display("FAIL busy_timeout: busy still %0d after %0d cycles, expected 0", busy, cycles);
    end
  endtask

  initial begin
    int          cyc_cnt;
    int          acks;
    logic [31:0] exp_ack;

    tbl[0] = '{6'd10, 1'b1, 32'd55,         3'b010};
    tbl[1] = '{6'd10, 1'b0, 32'd55,         3'b010};
    tbl[2] = '{6'd47, 1'b1, 32'hB11924E1,   3'b010};
    tbl[3] = '{6'd48, 1'b1, 32'h1E8D0A40,   3'b110};
    tbl[4] = '{6'd0,  1'b1, 32'd0,          3'b010};
    tbl[5] = '{6'd1,  1'b0, 32'd1,          3'b010};
    tbl[6] = '{6'd2,  1'b1, 32'd1,          3'b010};
    tbl[7] = '{6'd20, 1'b0, 32'd6765,       3'b010};

    rst_n = 1'b0;
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_i = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_value", fib_value, 32'h0);
    check("rst_dat", dat_o, 32'h0);
    rst_n = 1'b1;
    rd_check("rst_ctrl", A_CTRL, 32'h0);
    rd_check("rst_count", A_COUNT, 32'h0);
    rd_check("rst_stat", A_STAT, 32'h0);
    rd_check("rst_result", A_RESULT, 32'h0);

    for (int v = 0; v < 8; v++) begin
      wr(A_COUNT, {26'h0, tbl[v].n});
      wr(A_CTRL, {30'h0, tbl[v].irq_en, 1'b1});
      wait_idle(cyc_cnt);
      check($sformatf("v%0d_busy_cycles", v), cyc_cnt, 32'(tbl[v].n) + 32'd1);
      check($sformatf("v%0d_value", v), fib_value, tbl[v].res);
      check($sformatf("v%0d_irq", v), {31'h0, irq}, {31'h0, tbl[v].irq_en});
      rd_check($sformatf("v%0d_result", v), A_RESULT, tbl[v].res);
      rd_check($sformatf("v%0d_stat", v), A_STAT, {29'h0, tbl[v].stat});
      rd_check($sformatf("v%0d_index", v), A_INDEX, {26'h0, tbl[v].n});
      rd_check($sformatf("v%0d_ctrl", v), A_CTRL, {30'h0, tbl[v].irq_en, 1'b0});
    end

    // IRQ enable after completion, then W1C of done
    wr(A_CTRL, 32'h2);
    check("irq_late_enable", {31'h0, irq}, 32'h1);
    wr(A_STAT, 32'h0);
    rd_check("stat_w0_keeps_done", A_STAT, 32'h2);
    wr(A_STAT, 32'h2);
    rd_check("stat_w1c", A_STAT, 32'h0);
    check("irq_after_w1c", {31'h0, irq}, 32'h0);

    // COUNT upper bits ignored
    wr(A_COUNT, 32'hFFFF_FFC5);
    rd_check("count_mask", A_COUNT, 32'h5);

    // START and COUNT change while running
    wr(A_COUNT, 32'd10);
    wr(A_CTRL, 32'h1);
    check("run_busy", {31'h0, busy}, 32'h1);
    wr(A_COUNT, 32'd5);
    wr(A_CTRL, 32'h1);
    wait_idle(cyc_cnt);
    rd_check("restart_ignored_result", A_RESULT, 32'd55);
    rd_check("count_updated", A_COUNT, 32'd5);

    // Held strobe: ack every second cycle, data only with ack
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = A_RESULT; sel = 4'hF;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_ack = (i % 2 == 0) ? 32'h1 : 32'h0;
      check($sformatf("held_ack_%0d", i), {31'h0, ack}, exp_ack);
      check($sformatf("held_dat_%0d", i), dat_o, (i % 2 == 0) ? 32'd55 : 32'd0);
      if (ack) acks++;
    end
    check("held_ack_count", acks, 32'd4);
    stb = 1'b0; cyc = 1'b0;
    @(negedge clk);

    // Outside the decode window: never acked
    foreach (tbl[k]) begin end
    stb = 1'b1; cyc = 1'b1; adr = 32'h3000_0108;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    adr = 32'h2000_000C;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("miss_no_ack", acks, 32'd0);
    stb = 1'b0; cyc = 1'b0;

    // Unmapped offset inside the window: acked, reads 0
    rd_check("unmapped_read", 32'h3000_0020, 32'h0);

    // Reset in the middle of a run
    wr(A_CTRL, 32'h2);
    wr(A_COUNT, 32'd40);
    wr(A_CTRL, 32'h3);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_value", fib_value, 32'h0);
    check("midrst_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_check("midrst_result", A_RESULT, 32'h0);
    rd_check("midrst_stat", A_STAT, 32'h0);
    rd_check("midrst_ctrl", A_CTRL, 32'h0);
    rd_check("midrst_count", A_COUNT, 32'h0);
    wr(A_COUNT, 32'd10);
    wr(A_CTRL, 32'h1);
    wait_idle(cyc_cnt);
    check("restart_busy_cycles", cyc_cnt, 32'd11);
    rd_check("restart_result", A_RESULT, 32'd55);
    check("restart_irq_disabled", {31'h0, irq}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
